// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//
// Multi-channel switch debouncer. Each channel is processed independently:
//   raw input -> 2-FF synchroniser -> stability counter -> debounced level
//   -> registered rise/fall pulses and a long-press (hold) level flag.
//
// Parameters
//   N_CH        number of independent channels (>= 1)
//   STABLE_CYC  consecutive cycles the synchronised input must differ from the
//               debounced state before the new level is accepted (>= 2)
//   HOLD_CYC    cycles the debounced level must stay high after a rise before
//               o_long asserts; 0 removes the hold logic and ties o_long low
//   RST_VAL     reset value of the synchronisers and of the debounced output
//
// Ports
//   clk              clock
//   rst              asynchronous, active-high reset
//   i_sig            raw switch inputs, asynchronous to clk
//   o_sig_debounced  debounced, glitch-free level per channel
//   o_rise           one-cycle pulse when a debounced level goes 0->1
//   o_fall           one-cycle pulse when a debounced level goes 1->0
//   o_long           level: channel held high for >= HOLD_CYC cycles since rise
//   o_any_evt        OR of all rise/fall pulses, in the same cycle as the pulses
//
// No handshakes: every output is a plain registered level or pulse that is
// valid on every cycle; there is no valid/ready protocol on this block.
// The block has no FSM; the per-channel state is the counter values.
// -----------------------------------------------------------------------------
module debouncer_multi #(
  parameter int   N_CH       = 4,
  parameter int   STABLE_CYC = 8,
  parameter int   HOLD_CYC   = 32,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_sig,
  output logic [N_CH-1:0] o_sig_debounced,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic            o_any_evt
);

  // Stability counter only has to reach STABLE_CYC-1, so $clog2(STABLE_CYC)
  // bits are enough for any integer STABLE_CYC >= 2.
  localparam int            CW       = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  logic [N_CH-1:0]          sync1;
  logic [N_CH-1:0]          sync2;
  logic [N_CH-1:0][CW-1:0]  stab_cnt;
  logic [N_CH-1:0][CW-1:0]  stab_cnt_nxt;
  logic [N_CH-1:0]          deb_nxt;
  logic [N_CH-1:0]          rise_nxt;
  logic [N_CH-1:0]          fall_nxt;

  // ---------------------------------------------------------------------------
  // Two-stage synchroniser. Only sync2 is used downstream.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {N_CH{RST_VAL}};
      sync2 <= {N_CH{RST_VAL}};
    end else begin
      sync1 <= i_sig;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability counter, next-state logic.
  // The counter tracks how many consecutive edges sync2 has disagreed with the
  // debounced level. Any single agreeing cycle drops it back to zero, so a
  // level is only accepted after STABLE_CYC uninterrupted disagreeing edges.
  // The acceptance edge also produces the edge pulses, so the pulses line up
  // exactly with the change of o_sig_debounced.
  // ---------------------------------------------------------------------------
  always_comb begin
    stab_cnt_nxt = stab_cnt;
    deb_nxt      = o_sig_debounced;
    rise_nxt     = '0;
    fall_nxt     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sync2[c] == o_sig_debounced[c]) begin
        stab_cnt_nxt[c] = '0;
      end else if (stab_cnt[c] == CNT_LAST) begin
        deb_nxt[c]      = sync2[c];
        stab_cnt_nxt[c] = '0;
        rise_nxt[c]     = sync2[c];
        fall_nxt[c]     = ~sync2[c];
      end else begin
        stab_cnt_nxt[c] = stab_cnt[c] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt        <= '0;
      o_sig_debounced <= {N_CH{RST_VAL}};
      o_rise          <= '0;
      o_fall          <= '0;
      o_any_evt       <= 1'b0;
    end else begin
      stab_cnt        <= stab_cnt_nxt;
      o_sig_debounced <= deb_nxt;
      o_rise          <= rise_nxt;
      o_fall          <= fall_nxt;
      // Registered from the same next-state terms as the pulses so that it
      // appears in the same cycle rather than one cycle later.
      o_any_evt       <= |(rise_nxt | fall_nxt);
    end
  end

  // ---------------------------------------------------------------------------
  // Long-press detection.
  // The hold counter restarts on the rise edge, then counts every edge while
  // the debounced level is high, saturating at HOLD_CYC. o_long asserts on the
  // edge the counter reaches HOLD_CYC and drops on the fall edge.
  // ---------------------------------------------------------------------------
  if (HOLD_CYC > 0) begin : g_hold
    localparam int            HW       = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

    logic [N_CH-1:0][HW-1:0] hold_cnt;
    logic [N_CH-1:0][HW-1:0] hold_cnt_nxt;
    logic [N_CH-1:0]         long_nxt;

    always_comb begin
      hold_cnt_nxt = hold_cnt;
      long_nxt     = o_long;
      for (int c = 0; c < N_CH; c++) begin
        if (rise_nxt[c] || fall_nxt[c]) begin
          hold_cnt_nxt[c] = '0;
          long_nxt[c]     = 1'b0;
        end else if (o_sig_debounced[c]) begin
          if (hold_cnt[c] != HOLD_MAX) begin
            hold_cnt_nxt[c] = hold_cnt[c] + HW'(1);
          end
          long_nxt[c] = (hold_cnt_nxt[c] == HOLD_MAX);
        end else begin
          hold_cnt_nxt[c] = '0;
          long_nxt[c]     = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_cnt <= '0;
        o_long   <= '0;
      end else begin
        hold_cnt <= hold_cnt_nxt;
        o_long   <= long_nxt;
      end
    end
  end else begin : g_no_hold
    assign o_long = '0;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
//
// Directed bench for debouncer_multi (N_CH=4, STABLE_CYC=8, HOLD_CYC=32,
// RST_VAL=0). Every cycle goes through step(): the input is driven shortly
// after a rising edge, a reference model predicts the outputs after the next
// edge and pushes them to exp_q, and the entry is popped and compared 1 ns
// after that edge. Directed latency/pulse checks with fixed constants are
// layered on top of the per-cycle scoreboard.
//
// The reference model works on runs of identical synchronised samples: a new
// level is accepted once the current run of samples opposite to the debounced
// level has lasted STABLE_CYC edges.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

  localparam int   N_CH       = 4;
  localparam int   STABLE_CYC = 8;
  localparam int   HOLD_CYC   = 32;
  localparam logic RST_VAL    = 1'b0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk;
  logic            rst;
  logic [N_CH-1:0] i_sig;
  logic [N_CH-1:0] o_sig_debounced;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_long;
  logic            o_any_evt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debouncer_multi #(
    .N_CH       (N_CH),
    .STABLE_CYC (STABLE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .RST_VAL    (RST_VAL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_sig           (i_sig),
    .o_sig_debounced (o_sig_debounced),
    .o_rise          (o_rise),
    .o_fall          (o_fall),
    .o_long          (o_long),
    .o_any_evt       (o_any_evt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  // {deb[3:0], rise[3:0], fall[3:0], long[3:0], any}
  logic [16:0] exp_q[$];

  // Reference model state
  logic [N_CH-1:0] m_s1;
  logic [N_CH-1:0] m_s2;
  logic [N_CH-1:0] m_deb;
  logic [N_CH-1:0] m_long;
  logic [N_CH-1:0] m_rise;
  logic [N_CH-1:0] m_fall;
  logic [N_CH-1:0] run_val;
  int              run_len [N_CH];
  int              hold    [N_CH];

  // Directed-test scratch
  logic [N_CH-1:0] cur;
  logic [N_CH-1:0] rise_val;
  logic [4:0]      bounce_pat = 5'b01101;  // ch1 samples 1,0,1,1,0 (LSB first)
  int              at_edge;
  int              pulses;
  int              k;
  logic            found;
  logic            prev_long;
  logic            long_seen;
  logic            any_at_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1    = {N_CH{RST_VAL}};
    m_s2    = {N_CH{RST_VAL}};
    m_deb   = {N_CH{RST_VAL}};
    m_long  = '0;
    m_rise  = '0;
    m_fall  = '0;
    run_val = {N_CH{RST_VAL}};
    for (int c = 0; c < N_CH; c++) begin
      run_len[c] = 0;
      hold[c]    = 0;
    end
  endtask

  // Predict the outputs after the next rising edge, given the input driven now.
  task automatic model_edge(input logic [N_CH-1:0] v);
    logic [N_CH-1:0] s2_pre;
    logic            was_high;
    s2_pre = m_s2;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (run_len[c] > 0 && s2_pre[c] == run_val[c]) begin
        run_len[c]++;
      end else begin
        run_val[c] = s2_pre[c];
        run_len[c] = 1;
      end
      was_high = m_deb[c];
      if (run_val[c] != m_deb[c] && run_len[c] >= STABLE_CYC) begin
        m_deb[c]  = run_val[c];
        m_rise[c] = run_val[c];
        m_fall[c] = ~run_val[c];
      end
      if (m_rise[c] || m_fall[c]) begin
        hold[c]   = 0;
        m_long[c] = 1'b0;
      end else if (was_high) begin
        if (hold[c] < HOLD_CYC) hold[c]++;
        m_long[c] = (hold[c] >= HOLD_CYC);
      end else begin
        hold[c]   = 0;
        m_long[c] = 1'b0;
      end
    end
    m_s2 = m_s1;
    m_s1 = v;
  endtask

  // Driver + scoreboard for one clock cycle. Called 1 ns after a rising edge.
  task automatic step(input logic [N_CH-1:0] v);
    logic [16:0] e;
    i_sig = v;
    model_edge(v);
    exp_q.push_back({m_deb, m_rise, m_fall, m_long, |(m_rise | m_fall)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_deb",  o_sig_debounced, e[16:13]);
    chk("sb_rise", o_rise,          e[12:9]);
    chk("sb_fall", o_fall,          e[8:5]);
    chk("sb_long", o_long,          e[4:1]);
    chk("sb_any",  o_any_evt,       e[0]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_deb"},  o_sig_debounced, 0);
    chk({tag, "_rise"}, o_rise,          0);
    chk({tag, "_fall"}, o_fall,          0);
    chk({tag, "_long"}, o_long,          0);
    chk({tag, "_any"},  o_any_evt,       0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk_all_zero(tag);
    @(posedge clk);
    #1;
    chk_all_zero({tag, "_held"});
    rst = 1'b0;
    model_reset();
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    i_sig = '0;
    cur   = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("por");
    rst = 1'b0;

    // Clean press on ch0: rise after edge 9 counted from the first sample.
    cur[0] = 1'b1;
    step(cur);                       // edge 0
    at_edge = 0; pulses = 0; any_at_rise = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(cur);
      if (o_rise[0] && at_edge == 0) begin
        at_edge     = i;
        any_at_rise = o_any_evt;
      end
      pulses += int'(o_rise[0]);
    end
    chk("press_ch0_latency", at_edge, 9);
    chk("press_ch0_any_evt", any_at_rise, 1);
    chk("press_ch0_one_pulse", pulses, 1);
    chk("press_ch0_others_low", o_sig_debounced[3:1], 0);

    // Mid-cycle reset with ch0 debounced high, then a quiet 50 cycles.
    cur = '0;
    i_sig = cur;
    pulse_reset("rst_mid");
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(cur);
      pulses += int'(|{o_rise, o_fall, o_any_evt});
    end
    chk("quiet_after_rst", pulses, 0);

    // Bounce on ch1, then held high.
    for (int i = 0; i < 5; i++) begin
      cur[1] = bounce_pat[i];
      step(cur);
    end
    cur[1] = 1'b1;
    step(cur);                       // edge 0: final 0->1 sample
    at_edge = 0; pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      step(cur);
      if (o_rise[1] && at_edge == 0) at_edge = i;
      pulses += int'(o_rise[1]);
    end
    chk("bounce_ch1_latency", at_edge, 9);
    chk("bounce_ch1_one_pulse", pulses, 1);
    chk("bounce_ch1_level", o_sig_debounced[1], 1);

    // Glitch of STABLE_CYC-1 samples on ch2 must be rejected.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cur[2] = (i < STABLE_CYC - 1);
      step(cur);
      pulses += int'(o_rise[2] | o_fall[2]);
    end
    chk("glitch7_no_pulse", pulses, 0);
    chk("glitch7_level", o_sig_debounced[2], 0);

    // STABLE_CYC samples on ch2 are accepted, then released again.
    at_edge = 0;
    for (int i = 0; i <= 20; i++) begin
      cur[2] = (i < STABLE_CYC);
      step(cur);
      if (o_rise[2] && at_edge == 0) at_edge = i;
    end
    chk("glitch8_accept_edge", at_edge, 9);
    chk("glitch8_released", o_sig_debounced[2], 0);

    // Input toggling every cycle never changes the output.
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cur[2] = i[0];
      step(cur);
      pulses += int'(o_rise[2] | o_fall[2]);
    end
    chk("toggle_no_pulse", pulses, 0);
    chk("toggle_level", o_sig_debounced[2], 0);
    cur[2] = 1'b0;
    for (int i = 0; i < 3; i++) step(cur);

    // Long press on ch3.
    cur[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(cur);
      if (o_rise[3]) found = 1'b1;
    end
    chk("long_rise_seen", found, 1);
    k = 0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(cur);
      k++;
      if (o_long[3]) found = 1'b1;
    end
    chk("long_latency", k, HOLD_CYC);
    for (int i = 0; i < 5; i++) step(cur);
    chk("long_stays", o_long[3], 1);
    cur[3] = 1'b0;
    found = 1'b0; prev_long = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_long = o_long[3];
      step(cur);
      if (o_fall[3]) found = 1'b1;
    end
    chk("long_fall_seen", found, 1);
    chk("long_before_fall", prev_long, 1);
    chk("long_clear_on_fall", o_long[3], 0);

    // Release 20 cycles after the rise: o_long never asserts.
    cur[3] = 1'b1;
    found = 1'b0; long_seen = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(cur);
      if (o_rise[3]) found = 1'b1;
    end
    chk("short_rise_seen", found, 1);
    for (int i = 0; i < 20; i++) begin
      step(cur);
      long_seen |= o_long[3];
    end
    cur[3] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(cur);
      long_seen |= o_long[3];
    end
    chk("short_no_long", long_seen, 0);

    // Settle every channel low.
    cur = '0;
    for (int i = 0; i < 14; i++) step(cur);
    chk("settle_low", o_sig_debounced, 0);

    // ch0 and ch2 change on the same sample.
    cur = 4'b0101;
    step(cur);                       // edge 0
    at_edge = 0; rise_val = '0;
    for (int i = 1; i <= 12; i++) begin
      step(cur);
      if (o_rise != 0 && at_edge == 0) begin
        at_edge  = i;
        rise_val = o_rise;
      end
    end
    chk("simul_edge", at_edge, 9);
    chk("simul_rise_vec", rise_val, 4'b0101);

    // Reset while ch1 has counted to 5: a full count is needed afterwards.
    cur[1] = 1'b1;
    for (int i = 0; i <= 6; i++) step(cur);
    pulse_reset("rst_cnt");
    at_edge = 0; rise_val = '0;
    for (int i = 0; i <= 12; i++) begin
      step(cur);
      if (o_rise != 0 && at_edge == 0) begin
        at_edge  = i;
        rise_val = o_rise;
      end
    end
    chk("rst_cnt_edge", at_edge, 9);
    chk("rst_cnt_rise_vec", rise_val, 4'b0111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Multi-channel switch debouncer, the parametrised successor of the single-channel debouncer. Each of N_CH asynchronous switch inputs gets:
- a 2-FF synchroniser,
- a per-channel stability counter with an exact, non-power-of-2 bouncing interval,
- single-cycle rise/fall event pulses,
- a long-press (hold) level flag.

It sits between board push-buttons/DIP switches and control logic, replacing one debouncer instance per switch.

Parameters:
N_CH, 4, number of independent channels (>=1)
STABLE_CYC, 8, cycles the synchronised input must differ from the debounced state before it is accepted (>=2, any integer)
HOLD_CYC, 32, cycles the debounced state must stay high after a rise before o_long asserts (0 disables long-press; o_long tied 0)
RST_VAL, 1'b0, reset value of the synchronisers and the debounced output, applied to all channels

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_sig  input  N_CH  raw bouncing switch inputs, asynchronous to clk
o_sig_debounced  output  N_CH  debounced, glitch-free state per channel
o_rise  output  N_CH  1-cycle pulse when a channel's debounced state goes 0->1
o_fall  output  N_CH  1-cycle pulse when a channel's debounced state goes 1->0
o_long  output  N_CH  level: channel held high >= HOLD_CYC cycles since its rise
o_any_evt  output  1  registered OR of o_rise|o_fall across channels, same cycle as the pulses

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst=1: sync stages = RST_VAL, o_sig_debounced = RST_VAL, stability and hold counters = 0, o_rise/o_fall/o_long/o_any_evt = 0.
  - Deassertion produces no edge pulse.
  - Reset mid-count discards all progress.
- Channels are fully independent; nothing is shared except o_any_evt.
- Synchroniser: sync1 <= i_sig; sync2 <= sync1. Only sync2 is used downstream.
- Stability counter, per channel, width $clog2(STABLE_CYC), updated every clk edge:
  - if sync2 == debounced: cnt <= 0
  - else if cnt == STABLE_CYC-1: debounced <= sync2, cnt <= 0
  - else: cnt <= cnt+1
- Any single-cycle reversion of sync2 to the debounced value restarts the count from 0. There is no partial credit.
- Latency: a clean level change on i_sig first sampled at edge 0 appears on o_sig_debounced after edge STABLE_CYC+1.
- Event pulses are registered and asserted in the same cycle o_sig_debounced changes, for exactly 1 cycle:
  - o_rise = new & ~old
  - o_fall = ~new & old
  - Rise and fall on the same channel can never coincide.
  - Several channels may pulse in the same cycle.
- Hold counter, per channel, width $clog2(HOLD_CYC+1), saturating:
  - Cleared on the edge that raises debounced.
  - Increments each edge while debounced=1, saturating at HOLD_CYC.
  - o_long sets on the edge where the counter reaches HOLD_CYC, i.e. HOLD_CYC edges after the rise edge.
  - o_long clears on the same edge that produces o_fall.
  - Counter is held at 0 while debounced=0.
- No counter wraps. The stability counter never exceeds STABLE_CYC-1; the hold counter saturates.
- Inputs toggling every cycle forever: output never changes and no pulses are generated.
- Implementation: fully synchronous logic apart from the async reset; no latches, no combinational paths from input to output.

Test Plan:
1. Reset (N_CH=4, STABLE_CYC=8, RST_VAL=0): assert rst mid-cycle -> all outputs 0 immediately. Deassert with i_sig=4'b0000 -> no pulses for 50 cycles.
2. Clean press on ch0: i_sig[0] 0->1 sampled at edge 0, held -> o_sig_debounced[0]=1 and o_rise[0]=1 (1 cycle) and o_any_evt=1 after edge 9. Other channels stay 0.
3. Bounce on ch1: i_sig[1] toggles 1,0,1,1,0 over 5 cycles, then held 1 -> o_sig_debounced[1] rises exactly 9 edges after the final 0->1 sample; a single o_rise[1] pulse.
4. Glitch rejection: i_sig[2] high for 7 cycles (STABLE_CYC-1) then low -> o_sig_debounced[2] stays 0, no pulse. High for 8 cycles -> accepted.
5. Long press (HOLD_CYC=32): ch3 held high -> o_long[3] sets 32 edges after the o_rise[3] edge. Release -> o_long[3] clears on the o_fall[3] edge. Release after 20 cycles -> o_long never asserts.
6. Simultaneous events and reset mid-count: ch0 and ch2 change on the same sample -> o_rise=4'b0101 in one cycle. Also: rst pulsed while ch1 cnt=5 -> after release, a full 8-cycle stability count is required again.
